// File: rtl/ram_scan_viewer.sv
// ram_scan_viewer: single-clock RAM (one write, one read port) with a read-address
// sequencer. After reset the whole array is cleared to zero. Afterwards the read address
// either follows man_addr (MANUAL) or steps through every location on a dwell timer (SCAN).
// Read data is registered together with the address it belongs to. The address is also
// presented as two BCD digits for the HEX display drivers.
module ram_scan_viewer #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 4,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mode,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic              pause,
  output logic              busy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_tens,
  output logic [3:0]        out_ones
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]  ADDR_ZERO  = '0;
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0]  DATA_ZERO  = '0;
  localparam logic [DWELL_W-1:0] DWELL_ZERO = '0;
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // BCD tens digit of an address (addresses never exceed 63, so 8 bits suffice).
  function automatic logic [3:0] bcd_tens(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = 8'(a);
    return 4'(v / 8'd10);
  endfunction

  // BCD ones digit of an address.
  function automatic logic [3:0] bcd_ones(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = 8'(a);
    return 4'(v % 8'd10);
  endfunction

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   clr_ptr_q,  clr_ptr_d;
  logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
  logic [DWELL_W-1:0]  dwell_q,    dwell_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                busy_q,     busy_d;

  // Storage array; only ever written through the single write port below.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   rd_bypass_s;

  // Asynchronous array read at the current read address.
  assign rd_word_s = mem_q[rd_addr_q];

  // Write-first: a same-cycle write to the address being read wins over the stored word.
  always_comb begin
    if (wr_en && (wr_addr == rd_addr_q)) begin
      rd_bypass_s = wr_data;
    end else begin
      rd_bypass_s = rd_word_s;
    end
  end

  // Next-state, write-port steering and read-pipeline logic for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rd_addr_d   = rd_addr_q;
    dwell_d     = dwell_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = wr_addr;
    mem_wdata_d = wr_data;

    case (state_q)
      ST_CLEAR: begin
        // The clear sweep owns the write port; user writes are dropped.
        mem_we_d    = 1'b1;
        mem_waddr_d = clr_ptr_q;
        mem_wdata_d = DATA_ZERO;
        out_addr_d  = ADDR_ZERO;
        out_data_d  = DATA_ZERO;
        rd_addr_d   = ADDR_ZERO;
        dwell_d     = DWELL_ZERO;
        if (clr_ptr_q == ADDR_LAST) begin
          clr_ptr_d = ADDR_ZERO;
          busy_d    = 1'b0;
          if (mode) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_MANUAL;
          end
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_ONE;
          busy_d    = 1'b1;
        end
      end

      ST_MANUAL: begin
        mem_we_d   = wr_en;
        out_addr_d = rd_addr_q;
        out_data_d = rd_bypass_s;
        busy_d     = 1'b0;
        dwell_d    = DWELL_ZERO;
        if (mode) begin
          // Keep the last manual address so the scan starts from there.
          state_d = ST_SCAN;
        end else begin
          rd_addr_d = man_addr;
        end
      end

      ST_SCAN: begin
        mem_we_d   = wr_en;
        out_addr_d = rd_addr_q;
        out_data_d = rd_bypass_s;
        busy_d     = 1'b0;
        if (!mode) begin
          state_d = ST_MANUAL;
          dwell_d = DWELL_ZERO;
        end else if (pause) begin
          dwell_d = dwell_q;
        end else if (dwell_q == DWELL_LAST) begin
          // Natural ADDR_W-bit wrap takes DEPTH-1 back to 0.
          dwell_d   = DWELL_ZERO;
          rd_addr_d = rd_addr_q + ADDR_ONE;
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end

      default: begin
        // Unreachable encoding: recover by re-running the clear sweep.
        state_d    = ST_CLEAR;
        clr_ptr_d  = ADDR_ZERO;
        rd_addr_d  = ADDR_ZERO;
        dwell_d    = DWELL_ZERO;
        out_addr_d = ADDR_ZERO;
        out_data_d = DATA_ZERO;
        busy_d     = 1'b1;
      end
    endcase
  end

  // Sequencer and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= ADDR_ZERO;
      rd_addr_q  <= ADDR_ZERO;
      dwell_q    <= DWELL_ZERO;
      out_addr_q <= ADDR_ZERO;
      out_data_q <= DATA_ZERO;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_addr_q  <= rd_addr_d;
      dwell_q    <= dwell_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
    end
  end

  // Array write port; suppressed on the reset edge so the clear sweep restarts cleanly.
  always_ff @(posedge clock) begin
    if (!reset && mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  assign busy     = busy_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign out_tens = bcd_tens(out_addr_q);
  assign out_ones = bcd_ones(out_addr_q);

endmodule

// File: tb/tb_ram_scan_viewer.sv
// Self-checking bench for ram_scan_viewer: directed scenarios followed by random traffic.
// A behavioural model predicts every post-edge output and queues it; a monitor on the
// falling edge pops and compares.
module tb_ram_scan_viewer;

  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int DWELL = 4;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          mode = 1'b0;
  logic [AW-1:0] man_addr = '0;
  logic          pause = 1'b0;
  logic          busy;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [3:0]    out_tens;
  logic [3:0]    out_ones;

  ram_scan_viewer #(.ADDR_W(AW), .DATA_W(DW), .DWELL_CYCLES(DWELL)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mode(mode), .man_addr(man_addr), .pause(pause), .busy(busy), .out_addr(out_addr),
    .out_data(out_data), .out_tens(out_tens), .out_ones(out_ones)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit busy;
    int addr;
    int data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: memory contents, clear progress, viewing cursor and dwell time.
  int m_mem [DEPTH];
  bit m_clearing = 1'b0;
  int m_cleared  = 0;
  bit m_scan     = 1'b0;
  int m_cur      = 0;
  int m_dwell    = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs and queue the prediction.
  task automatic model_edge(input bit r, input bit we, input int wa, input int wd,
                            input bit md, input int ma, input bit ps);
    exp_t e;
    if (r) begin
      m_clearing = 1'b1;
      m_cleared  = 0;
      m_cur      = 0;
      m_dwell    = 0;
      e.busy = 1'b1; e.addr = 0; e.data = 0;
    end else if (m_clearing) begin
      m_mem[m_cleared] = 0;
      m_cleared++;
      e.busy = 1'b1; e.addr = 0; e.data = 0;
      if (m_cleared == DEPTH) begin
        m_clearing = 1'b0;
        m_scan     = md;
        e.busy     = 1'b0;
      end
    end else begin
      e.busy = 1'b0;
      e.addr = m_cur;
      e.data = (we && wa == m_cur) ? wd : m_mem[m_cur];
      if (we) m_mem[wa] = wd;
      if (!m_scan) begin
        if (md) m_scan = 1'b1;
        else    m_cur  = ma;
      end else if (!md) begin
        m_scan  = 1'b0;
        m_dwell = 0;
      end else if (!ps) begin
        m_dwell++;
        if (m_dwell == DWELL) begin
          m_dwell = 0;
          m_cur   = (m_cur + 1) % DEPTH;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  // One cycle: drive inputs, let the edge happen, predict, then return at the falling edge.
  task automatic step(input bit r, input bit we, input int wa, input int wd,
                      input bit md, input int ma, input bit ps);
    reset    = r;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = DW'(wd);
    mode     = md;
    man_addr = AW'(ma);
    pause    = ps;
    @(posedge clock);
    model_edge(r, we, wa, wd, md, ma, ps);
    @(negedge clock);
  endtask

  // Monitor: compare every queued prediction against the settled outputs.
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("busy", 32'(busy), int'(e.busy));
      chk("out_addr", 32'(out_addr), e.addr);
      chk("out_data", 32'(out_data), e.data);
      chk("out_tens", 32'(out_tens), e.addr / 10);
      chk("out_ones", 32'(out_ones), e.addr % 10);
    end
  end

  initial begin
    int n_busy;
    bit md;
    bit ps;

    // Clear after a one-cycle reset; busy must stay up for exactly DEPTH observed cycles.
    step(1, 0, 0, 0, 0, 0, 0);
    n_busy = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, i % DEPTH, 4'hF, 0, 0, 0);
      if (busy) n_busy++;
    end
    chk("busy_cycles", 32'(n_busy), DEPTH);
    for (int a = 0; a < DEPTH + 2; a++) step(0, 0, 0, 0, 0, a % DEPTH, 0);

    // Manual write then read back address 17.
    step(0, 1, 17, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 17, 0);

    // Write-first bypass on the address currently being viewed.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 3, 0);
    step(0, 1, 3, 4'hA, 0, 3, 0);
    step(0, 0, 0, 0, 0, 3, 0);

    // Scan from 30 across the wrap, then pause mid-dwell and resume.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 30, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, 0);

    // Reset in the middle of a scan at address 12 after writing data.
    for (int i = 0; i < 8; i++) step(0, 1, (i * 5) % DEPTH, i + 1, 0, 12, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 34; i++) step(0, 1, i % DEPTH, 4'h7, 0, 0, 0);
    for (int a = 0; a < DEPTH + 2; a++) step(0, 0, 0, 0, 0, a % DEPTH, 0);

    // Random traffic with occasional mode flips, pauses and resets.
    md = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) md = ~md;
      ps = ($urandom_range(0, 4) == 0);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)),
           md, int'($urandom_range(0, DEPTH - 1)), ps);
    end

    @(negedge clock);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
